// File: rtl/cdb_pkg.sv
// Shared constants and types for the common-data-bus arbiter.
// Default sizes, FSM state encoding and the broadcast beat layout.
package cdb_pkg;

   localparam int CDB_NUM_SRC = 8;
   localparam int CDB_DATA_W  = 32;
   localparam int CDB_TAG_W   = 4;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_HI_PEND = 1'b1
   } cdb_state_e;

   typedef struct packed {
      logic                  valid;
      logic [CDB_DATA_W-1:0] data;
      logic [CDB_TAG_W-1:0]  tag;
      logic                  hi;
   } cdb_bcast_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Source request/grant bundle plus the registered CDB broadcast.
// master = result sources side, slave = arbiter side.
interface cdb_arbiter_if
   import cdb_pkg::*;
#(
   parameter int NUM_SRC = CDB_NUM_SRC,
   parameter int DATA_W  = CDB_DATA_W,
   parameter int TAG_W   = CDB_TAG_W
);

   logic [NUM_SRC-1:0]             src_valid;
   logic [NUM_SRC-1:0]             src_wide;
   logic [NUM_SRC-1:0][DATA_W-1:0] src_data;
   logic [NUM_SRC-1:0][DATA_W-1:0] src_data_hi;
   logic [NUM_SRC-1:0][TAG_W-1:0]  src_tag;
   logic                           flush;
   logic [NUM_SRC-1:0]             src_grant;
   logic                           cdb_valid;
   logic [DATA_W-1:0]              cdb_data;
   logic [TAG_W-1:0]               cdb_tag;
   logic                           cdb_hi;

   modport master (
      output src_valid, src_wide, src_data, src_data_hi,
      output src_tag, flush,
      input  src_grant, cdb_valid, cdb_data, cdb_tag, cdb_hi
   );

   modport slave (
      input  src_valid, src_wide, src_data, src_data_hi,
      input  src_tag, flush,
      output src_grant, cdb_valid, cdb_data, cdb_tag, cdb_hi
   );

endinterface

// File: rtl/cdb_rr_picker.sv
// Rotating one-hot priority encoder: search starts at ptr and wraps.
// ptr tied to 0 degenerates to fixed lowest-index priority.
module cdb_rr_picker #(
   parameter int N     = 8,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   always_comb begin
      logic [PTR_W:0] c;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = '0;
      for (int i = 0; i < N; i++) begin
         c = {1'b0, ptr} + (PTR_W+1)'(i);
         if (c >= (PTR_W+1)'(N)) c = c - (PTR_W+1)'(N);
         if (!any && req[c[PTR_W-1:0]]) begin
            any                 = 1'b1;
            gnt[c[PTR_W-1:0]]   = 1'b1;
            idx                 = c[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one grant per cycle, registered broadcast, two-beat wide results.
// Define CDB_ARBITER_RR_EN for round-robin; otherwise lowest index wins.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_SRC = CDB_NUM_SRC,
   parameter int DATA_W  = CDB_DATA_W,
   parameter int TAG_W   = CDB_TAG_W
) (
   input logic           clk,
   input logic           reset_n,
   cdb_arbiter_if.slave  bus
);

   localparam int         PTR_W     = $clog2(NUM_SRC);
   localparam logic [0:0] S_IDLE    = ST_IDLE;
   localparam logic [0:0] S_HI_PEND = ST_HI_PEND;

   logic [0:0]         state_q, state_d;
   logic [PTR_W-1:0]   ptr;
   logic [NUM_SRC-1:0] pick_gnt;
   logic [PTR_W-1:0]   pick_idx;
   logic               pick_any;
   logic               gnt_en;
   logic               gnt_any;

   logic               vld_q, vld_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               hi_q, hi_d;
   logic [DATA_W-1:0]  pend_data_q, pend_data_d;
   logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;

   cdb_rr_picker #(
      .N     (NUM_SRC),
      .PTR_W (PTR_W)
   ) u_pick (
      .req (bus.src_valid),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Flush and the upper-beat slot both block new grants.
   assign gnt_en        = (state_q == S_IDLE) && !bus.flush;
   assign gnt_any       = gnt_en && pick_any;
   assign bus.src_grant = gnt_en ? pick_gnt : '0;

`ifdef CDB_ARBITER_RR_EN
   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         ptr_d = (pick_idx == PTR_W'(NUM_SRC-1)) ? '0
               : pick_idx + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   always_comb begin
      state_d     = state_q;
      vld_d       = 1'b0;
      data_d      = '0;
      tag_d       = '0;
      hi_d        = 1'b0;
      pend_data_d = pend_data_q;
      pend_tag_d  = pend_tag_q;
      if (bus.flush) begin
         state_d     = S_IDLE;
         pend_data_d = '0;
         pend_tag_d  = '0;
      end else if (state_q == S_HI_PEND) begin
         vld_d   = 1'b1;
         hi_d    = 1'b1;
         data_d  = pend_data_q;
         tag_d   = pend_tag_q;
         state_d = S_IDLE;
      end else if (gnt_any) begin
         vld_d  = 1'b1;
         data_d = bus.src_data[pick_idx];
         tag_d  = bus.src_tag[pick_idx];
         if (bus.src_wide[pick_idx]) begin
            state_d     = S_HI_PEND;
            pend_data_d = bus.src_data_hi[pick_idx];
            pend_tag_d  = bus.src_tag[pick_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         vld_q       <= 1'b0;
         data_q      <= '0;
         tag_q       <= '0;
         hi_q        <= 1'b0;
         pend_data_q <= '0;
         pend_tag_q  <= '0;
      end else begin
         state_q     <= state_d;
         vld_q       <= vld_d;
         data_q      <= data_d;
         tag_q       <= tag_d;
         hi_q        <= hi_d;
         pend_data_q <= pend_data_d;
         pend_tag_q  <= pend_tag_d;
      end
   end

   assign bus.cdb_valid = vld_q;
   assign bus.cdb_data  = data_q;
   assign bus.cdb_tag   = tag_q;
   assign bus.cdb_hi    = hi_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: driver queues expected beats,
// a negedge monitor pops and compares every broadcast cycle.
module tb_cdb_arbiter;
   import cdb_pkg::*;

`ifdef CDB_ARBITER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_err;

   logic [31:0] lo_d [8];
   logic [31:0] hi_d [8];
   logic [3:0]  tg   [8];

   cdb_bcast_t exp_q [$];

   cdb_arbiter_if #(.NUM_SRC(8), .DATA_W(32), .TAG_W(4)) bus ();

   cdb_arbiter #(
      .NUM_SRC (8),
      .DATA_W  (32),
      .TAG_W   (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] oh(input int i);
      logic [7:0] v;
      v = 8'd1;
      return v << i;
   endfunction

   function automatic cdb_bcast_t bl(input int i);
      cdb_bcast_t b;
      b = '{valid: 1'b1, data: lo_d[i], tag: tg[i], hi: 1'b0};
      return b;
   endfunction

   function automatic cdb_bcast_t bh(input int i);
      cdb_bcast_t b;
      b = '{valid: 1'b1, data: hi_d[i], tag: tg[i], hi: 1'b1};
      return b;
   endfunction

   function automatic cdb_bcast_t bz();
      cdb_bcast_t b;
      b = '0;
      return b;
   endfunction

   task automatic step(input logic r, input logic [7:0] v,
                       input logic [7:0] w, input logic f,
                       input logic [7:0] g, input cdb_bcast_t e);
      @(negedge clk);
      #1;
      reset_n       = r;
      bus.src_valid = v;
      bus.src_wide  = w;
      bus.flush     = f;
      #1;
      n_cmp++;
      if (bus.src_grant !== g) begin
         n_err++;
         $display("FAIL src_grant t=%0t got %b want %b",
                  $time, bus.src_grant, g);
      end
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, bz());
   endtask

   initial begin : monitor
      cdb_bcast_t a;
      cdb_bcast_t e;
      forever begin
         @(negedge clk);
         a = '{valid: bus.cdb_valid, data: bus.cdb_data,
               tag: bus.cdb_tag, hi: bus.cdb_hi};
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a !== e) begin
               n_err++;
               $display("FAIL cdb_beat t=%0t got v=%b d=%h tag=%h hi=%b want v=%b d=%h tag=%h hi=%b",
                        $time, a.valid, a.data, a.tag, a.hi,
                        e.valid, e.data, e.tag, e.hi);
            end
         end else if (bus.cdb_valid === 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL cdb_unexpected t=%0t got d=%h tag=%h want no beat",
                     $time, a.data, a.tag);
         end
      end
   end

   initial begin : driver
      n_cmp   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         lo_d[i] = 32'h11 * (i + 1);
         hi_d[i] = 32'hB0B0_0000 | i;
         tg[i]   = 4'(i + 1);
      end
      lo_d[2] = 32'hAAAA_0000;
      hi_d[2] = 32'h0000_BBBB;
      tg[2]   = 4'd5;
      bus.src_valid = '0;
      bus.src_wide  = '0;
      bus.flush     = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.src_data[i]    = lo_d[i];
         bus.src_data_hi[i] = hi_d[i];
         bus.src_tag[i]     = tg[i];
      end

      // reset state
      step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, bz());
      step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, bz());

      // narrow back-to-back, then idle zeros
      step(1'b1, oh(0) | oh(3), 8'h00, 1'b0, oh(0), bl(0));
      step(1'b1, oh(3), 8'h00, 1'b0, oh(3), bl(3));
      idle();

      // wide grant blocks grants during the upper beat
      step(1'b1, oh(2), oh(2), 1'b0, oh(2), bl(2));
      step(1'b1, oh(5) | oh(6), 8'h00, 1'b0, 8'h00, bh(2));
      step(1'b1, oh(5) | oh(6), 8'h00, 1'b0, oh(5), bl(5));
      step(1'b1, oh(6), 8'h00, 1'b0, oh(6), bl(6));
      idle();

      // flush squashes the pending upper beat
      step(1'b1, oh(1), oh(1), 1'b0, oh(1), bl(1));
      step(1'b1, oh(3), 8'h00, 1'b1, 8'h00, bz());
      step(1'b1, oh(0) | oh(3), 8'h00, 1'b0,
           RR ? oh(3) : oh(0), RR ? bl(3) : bl(0));
      step(1'b1, RR ? oh(0) : oh(3), 8'h00, 1'b0,
           RR ? oh(0) : oh(3), RR ? bl(0) : bl(3));
      idle();

      // flush with a wide request pending: no grant, no capture
      step(1'b1, oh(4), oh(4), 1'b1, 8'h00, bz());
      step(1'b1, oh(4), oh(4), 1'b0, oh(4), bl(4));
      step(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, bh(4));
      idle();

      // reset during the upper beat, pointer back to 0
      step(1'b1, oh(2), oh(2), 1'b0, oh(2), bl(2));
      step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, bz());
      step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, bz());
      step(1'b1, oh(0) | oh(7), 8'h00, 1'b0, oh(0), bl(0));
      step(1'b1, oh(7), 8'h00, 1'b0, oh(7), bl(7));
      idle();

      // all sources requesting continuously
      for (int k = 0; k < 9; k++) begin
         step(1'b1, 8'hFF, 8'h00, 1'b0,
              RR ? oh(k % 8) : oh(0), bl(RR ? k % 8 : 0));
      end
      idle();

      // sources 1 and 5 held
      for (int k = 0; k < 4; k++) begin
         step(1'b1, oh(1) | oh(5), 8'h00, 1'b0,
              (RR && (k % 2 == 1)) ? oh(5) : oh(1),
              bl((RR && (k % 2 == 1)) ? 5 : 1));
      end
      idle();
      idle();

      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain got %0d beats left want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 8: number of result sources (legal 2..16).
REQ-002 Parameter DATA_W, default 32: broadcast data width.
REQ-003 Parameter TAG_W, default 4: reservation-station tag width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 src_valid  input  NUM_SRC  per-source result request; held until granted.
REQ-007 src_wide  input  NUM_SRC  per-source flag: result is two beats (lower, upper).
REQ-008 src_data  input  NUM_SRC x DATA_W  per-source lower/only result word.
REQ-009 src_data_hi  input  NUM_SRC x DATA_W  per-source upper word; sampled only at grant when src_wide is set.
REQ-010 src_tag  input  NUM_SRC x TAG_W  per-source producer tag.
REQ-011 flush  input  1  synchronous squash of in-flight broadcast.
REQ-012 src_grant  output  NUM_SRC  one-hot combinational grant; source drops the request after a granted cycle.
REQ-013 cdb_valid  output  1  registered broadcast valid.
REQ-014 cdb_data  output  DATA_W  registered broadcast data.
REQ-015 cdb_tag  output  TAG_W  registered broadcast tag.
REQ-016 cdb_hi  output  1  registered; 1 marks the upper beat of a wide result.

Function
REQ-017 At most one src_grant bit SHALL be set per cycle; none when no src_valid is set.
REQ-018 Grant in cycle T SHALL produce cdb_valid=1 with that source's src_data/src_tag and cdb_hi=0 in cycle T+1 (latency 1).
REQ-019 Narrow grants SHALL be issuable every cycle; back-to-back broadcasts SHALL carry no bubble.
REQ-020 State machine: IDLE (grants allowed) and HI_PEND (no grants).
REQ-021 Wide grant in IDLE SHALL capture src_data_hi and src_tag into a pending register and move to HI_PEND.
REQ-022 In HI_PEND the cycle after a wide grant, src_grant SHALL be 0; next cycle cdb_valid=1, cdb_hi=1, cdb_data = captured upper word, cdb_tag = same tag; state returns to IDLE.
REQ-023 Arbitration SHALL be round-robin: priority starts at the index after the last granted source and wraps from NUM_SRC-1 to 0.
REQ-024 The round-robin pointer SHALL advance only on a grant, to (granted index + 1) mod NUM_SRC.
REQ-025 A cycle with no grant and no pending upper beat SHALL yield cdb_valid=0, cdb_data=0, cdb_tag=0, cdb_hi=0 next cycle.
REQ-026 flush=1 SHALL force src_grant=0 that cycle, clear cdb_valid in the next cycle, discard any pending upper beat and return to IDLE; the pointer is retained.
REQ-027 flush concurrent with a wide grant's capture cycle SHALL take precedence; no capture occurs.
REQ-028 A request that deasserts before grant SHALL NOT be broadcast.

Reset
REQ-029 While reset_n=0: cdb_valid=0, cdb_data=0, cdb_tag=0, cdb_hi=0, state=IDLE, pointer=0, pending register cleared.
REQ-030 Reset assertion mid wide transfer SHALL drop the upper beat; first grant after release follows pointer=0 priority.

Configuration
REQ-031 Macro CDB_ARBITER_RR_EN defined: round-robin per REQ-023/024.
REQ-032 Macro CDB_ARBITER_RR_EN undefined: fixed priority, lowest index wins; pointer logic absent; all other behaviour unchanged.

Structure
REQ-033 Package cdb_pkg SHALL hold default NUM_SRC/DATA_W/TAG_W constants, the IDLE/HI_PEND state enum and a broadcast struct (valid, data, tag, hi).
REQ-034 Sub-module cdb_rr_picker SHALL implement the rotating one-hot priority encoder (request vector + pointer -> grant); fixed priority uses pointer tied to 0.

Verification
REQ-035 Sources 0 and 3 narrow (tags 1, 4, data 0x11, 0x44), pointer 0 -> grant src0 T, src3 T+1; cdb shows tag 1/0x11 at T+1, tag 4/0x44 at T+2, no bubble.
REQ-036 Source 2 wide (lo 0xAAAA0000, hi 0x0000BBBB, tag 5) -> cdb lo/hi=0 at T+1, hi/hi=1 tag 5 at T+2; src_grant=0 at T+1 despite other requests.
REQ-037 All 8 sources request continuously with RR enabled -> grant order 0..7 then 0 again; each source granted once per 8 cycles.
REQ-038 flush in the cycle after wide grant from source 1 -> no cdb_hi=1 beat appears; state IDLE; next grant proceeds from pointer 2.
REQ-039 reset_n low for 2 cycles during HI_PEND -> all outputs 0; after release source 7 and 0 requesting -> source 0 granted first.
REQ-040 Build without CDB_ARBITER_RR_EN, sources 1 and 5 held requesting -> source 1 granted every cycle, source 5 starved.
